// File: rtl/interval_counter.sv
`default_nettype none
// ============================================================================
//  Module      : interval_counter
//  Description : Parametrised timebase. Divides CLK_HZ down to a TICK_HZ
//                strobe and steps a modulo-MODULUS up/down counter with
//                enable, clear, load and wrap indication for cascading.
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 8,
    parameter int MODULUS = 0,
    parameter int PW      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count_val,
    output logic             tick,
    output logic             wrap
);

    localparam int               c_div    = CLK_HZ / TICK_HZ;
    localparam logic [PW-1:0]    c_div_m1 = PW'(c_div - 1);
    localparam logic [WIDTH-1:0] c_max    = (MODULUS == 0) ? {WIDTH{1'b1}}
                                                           : WIDTH'(MODULUS - 1);

    // Reject parameter sets that cannot produce a well-formed period or range.
    generate
        if (TICK_HZ <= 0 || (CLK_HZ % TICK_HZ) != 0 || c_div < 2) begin : g_bad_div
            $error("interval_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if (PW < 32 && ((c_div - 1) >> PW) != 0) begin : g_bad_pw
            $error("interval_counter: DIV-1 does not fit in PW bits");
        end
        if (MODULUS < 0 || (MODULUS > 0 && WIDTH < 32 && ((MODULUS - 1) >> WIDTH) != 0))
        begin : g_bad_modulus
            $error("interval_counter: MODULUS must be 0 or <= 2**WIDTH");
        end
    endgenerate

    logic [PW-1:0]    prescaler_q, prescaler_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic             w_period_end;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_period_end = (prescaler_q == c_div_m1);

    // Out-of-range load values collapse to zero so the count never leaves 0..MAX.
    generate
        if (MODULUS == 0) begin : g_full_range
            assign w_load_clamped = load_val;
        end else begin : g_modulo_range
            localparam logic [WIDTH:0] c_modulus = (WIDTH + 1)'(MODULUS);
            assign w_load_clamped = ({1'b0, load_val} >= c_modulus) ? '0 : load_val;
        end
    endgenerate

    always_comb begin
        prescaler_d = prescaler_q;
        count_d     = count_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;

        if (clear) begin
            prescaler_d = '0;
            count_d     = '0;
        end else begin
            if (enable) begin
                if (w_period_end) begin
                    prescaler_d = '0;
                    tick_d      = 1'b1;
                end else begin
                    prescaler_d = prescaler_q + PW'(1);
                end
            end

            // A load on a tick edge overrides the step and suppresses wrap,
            // while the tick itself still fires.
            if (load) begin
                count_d = w_load_clamped;
            end else if (enable && w_period_end) begin
                if (up_dn) begin
                    if (count_q == c_max) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = c_max;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            count_q     <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign count_val = count_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interval_counter
//  Description : Directed self-checking bench for interval_counter, using a
//                DIV=10 / MODULUS=6 instance and a full-range 8-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_enable, a_clear, a_load, a_up_dn;
    logic [3:0] a_load_val, a_count;
    logic       a_tick, a_wrap;

    logic       b_reset, b_enable, b_clear, b_load, b_up_dn;
    logic [7:0] b_load_val, b_count;
    logic       b_tick, b_wrap;

    interval_counter #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .WIDTH  (4),
        .MODULUS(6),
        .PW     (8)
    ) u_dut_a (
        .clk      (clk),
        .reset    (a_reset),
        .enable   (a_enable),
        .clear    (a_clear),
        .load     (a_load),
        .load_val (a_load_val),
        .up_dn    (a_up_dn),
        .count_val(a_count),
        .tick     (a_tick),
        .wrap     (a_wrap)
    );

    interval_counter #(
        .CLK_HZ (20),
        .TICK_HZ(1),
        .WIDTH  (8),
        .MODULUS(0),
        .PW     (32)
    ) u_dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .enable   (b_enable),
        .clear    (b_clear),
        .load     (b_load),
        .load_val (b_load_val),
        .up_dn    (b_up_dn),
        .count_val(b_count),
        .tick     (b_tick),
        .wrap     (b_wrap)
    );

    int n_checks      = 0;
    int n_errors      = 0;
    int n_orphan_wrap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of edges taken until tick is seen high.
    task automatic wait_tick(input bit sel, output int edges);
        logic t;
        edges = 0;
        t     = 1'b0;
        while (!t && edges < 200) begin
            step(1);
            edges++;
            t = sel ? b_tick : a_tick;
        end
        if (!t) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_a();
        a_reset = 1'b1;
        step(1);
        a_reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (a_wrap && !a_tick) n_orphan_wrap++;
        if (b_wrap && !b_tick) n_orphan_wrap++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int quiet_bad;

        a_reset = 1'b1; a_enable = 1'b1; a_clear = 1'b0; a_load = 1'b0;
        a_up_dn = 1'b1; a_load_val = 4'd0;
        b_reset = 1'b1; b_enable = 1'b1; b_clear = 1'b0; b_load = 1'b0;
        b_up_dn = 1'b1; b_load_val = 8'd0;

        step(2);
        check("reset_count", 32'(a_count), 32'd0);
        check("reset_tick",  32'(a_tick),  32'd0);
        check("reset_wrap",  32'(a_wrap),  32'd0);
        a_reset = 1'b0;

        // Count up through a full modulo-6 cycle.
        for (int k = 1; k <= 6; k++) begin
            wait_tick(1'b0, e);
            check("up_period", 32'(e), 32'd10);
            check("up_count",  32'(a_count), 32'(k % 6));
            check("up_wrap",   32'(a_wrap),  32'(k == 6));
        end
        step(1);
        check("tick_one_cycle", 32'(a_tick), 32'd0);

        // Count down from reset: immediate wrap to MAX.
        a_up_dn = 1'b0;
        reset_a();
        wait_tick(1'b0, e);
        check("dn_first_period", 32'(e), 32'd10);
        check("dn_first_count",  32'(a_count), 32'd5);
        check("dn_first_wrap",   32'(a_wrap),  32'd1);
        wait_tick(1'b0, e);
        check("dn_second_count", 32'(a_count), 32'd4);
        check("dn_second_wrap",  32'(a_wrap),  32'd0);

        // Seven disabled cycles four cycles into a period.
        a_up_dn = 1'b1;
        reset_a();
        step(4);
        a_enable  = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            quiet_bad += int'(a_tick) + int'(a_wrap);
        end
        check("disabled_quiet", 32'(quiet_bad), 32'd0);
        a_enable = 1'b1;
        wait_tick(1'b0, e);
        check("gap_remaining", 32'(e), 32'd6);
        check("gap_count",     32'(a_count), 32'd1);

        // Load on a tick edge that would otherwise wrap.
        reset_a();
        repeat (5) wait_tick(1'b0, e);
        check("pre_load_count", 32'(a_count), 32'd5);
        step(9);
        a_load = 1'b1; a_load_val = 4'd3;
        step(1);
        check("load_tick_count", 32'(a_count), 32'd3);
        check("load_tick_tick",  32'(a_tick),  32'd1);
        check("load_tick_wrap",  32'(a_wrap),  32'd0);
        a_load_val = 4'd9;
        step(1);
        check("load_clamp", 32'(a_count), 32'd0);
        a_load = 1'b0;

        // Reset six cycles into a period at count 4.
        reset_a();
        repeat (4) wait_tick(1'b0, e);
        check("pre_reset_count", 32'(a_count), 32'd4);
        step(6);
        a_reset = 1'b1;
        step(1);
        check("midrst_count", 32'(a_count), 32'd0);
        check("midrst_tick",  32'(a_tick),  32'd0);
        check("midrst_wrap",  32'(a_wrap),  32'd0);
        a_reset = 1'b0;
        wait_tick(1'b0, e);
        check("midrst_period", 32'(e), 32'd10);
        check("midrst_after",  32'(a_count), 32'd1);

        // Same scenario with clear instead of reset.
        repeat (3) wait_tick(1'b0, e);
        check("pre_clear_count", 32'(a_count), 32'd4);
        step(6);
        a_clear = 1'b1;
        step(1);
        check("clear_count", 32'(a_count), 32'd0);
        check("clear_tick",  32'(a_tick),  32'd0);
        a_clear = 1'b0;
        wait_tick(1'b0, e);
        check("clear_period", 32'(e), 32'd10);
        check("clear_after",  32'(a_count), 32'd1);

        // Clear beats load.
        step(3);
        a_clear = 1'b1; a_load = 1'b1; a_load_val = 4'd2;
        step(1);
        check("clear_over_load", 32'(a_count), 32'd0);
        a_clear = 1'b0; a_load = 1'b0;
        wait_tick(1'b0, e);
        check("cl_period", 32'(e), 32'd10);

        // Mid-period load leaves the prescaler phase untouched.
        step(3);
        a_load = 1'b1; a_load_val = 4'd4;
        step(1);
        check("mid_load_count", 32'(a_count), 32'd4);
        a_load = 1'b0;
        wait_tick(1'b0, e);
        check("mid_load_phase", 32'(e), 32'd6);
        check("mid_load_next",  32'(a_count), 32'd5);
        check("mid_load_wrap",  32'(a_wrap),  32'd0);

        // Direction change between ticks applies at the next tick.
        step(2);
        check("hold_between_ticks", 32'(a_count), 32'd5);
        a_up_dn = 1'b0;
        wait_tick(1'b0, e);
        check("dir_change_period", 32'(e), 32'd8);
        check("dir_change_count",  32'(a_count), 32'd4);
        check("dir_change_wrap",   32'(a_wrap),  32'd0);

        // Full-range 8-bit instance: 255 wraps to 0, no clamping on load.
        b_reset = 1'b0;
        b_load = 1'b1; b_load_val = 8'd255;
        step(1);
        check("b_load_255", 32'(b_count), 32'd255);
        b_load = 1'b0;
        wait_tick(1'b1, e);
        check("b_first_period", 32'(e), 32'd19);
        check("b_wrap_count",   32'(b_count), 32'd0);
        check("b_wrap_flag",    32'(b_wrap),  32'd1);
        wait_tick(1'b1, e);
        check("b_period",     32'(e), 32'd20);
        check("b_next_count", 32'(b_count), 32'd1);
        check("b_next_wrap",  32'(b_wrap),  32'd0);
        b_load = 1'b1; b_load_val = 8'd200;
        step(1);
        check("b_load_200", 32'(b_count), 32'd200);
        b_load = 1'b0;

        step(2);
        check("wrap_only_with_tick", 32'(n_orphan_wrap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interval_counter.md
Name: interval_counter

Overview:
- Parametrised successor to the fixed 100 MHz seconds counter.
- Divides an arbitrary clock (CLK_HZ) down to a TICK_HZ strobe and drives a modulo-MODULUS up/down count with enable, clear, load and wrap indication.
- Used as a generic timebase: seconds, minutes or any interval, cascadable via `wrap`.
- Sits beside user logic as a free-running timer; no bus interface.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 1, tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2, checked at elaboration (error otherwise).
- WIDTH, 8, count_val width.
- MODULUS, 0, count range 0..MODULUS-1. 0 means full 2^WIDTH range; nonzero must be <= 2^WIDTH.
- PW, 32, prescaler width; DIV-1 must fit in PW bits.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = prescaler advances; 0 = prescaler and count hold.
- clear  in  1  synchronous restart of prescaler and count to 0.
- load  in  1  synchronous load of load_val into count.
- load_val  in  WIDTH  value loaded on load.
- up_dn  in  1  1 = count up, 0 = count down; sampled at each tick.
- count_val  out  WIDTH  current count, registered.
- tick  out  1  one-cycle pulse per DIV enabled cycles.
- wrap  out  1  one-cycle pulse, coincident with tick, when count wraps.

Behaviour:
- Reset state: prescaler=0, count_val=0, tick=0, wrap=0. All state is registered; no combinational outputs.
- Priority per edge: reset > clear > load > enable/tick.
- Prescaler:
  - Each edge with enable=1: if prescaler==DIV-1 it becomes 0 and tick<=1; otherwise it increments and tick<=0.
  - enable=0: prescaler holds, tick<=0, wrap<=0.
- Tick timing: first tick is high in the cycle following the DIV-th enabled edge after the edge that sampled reset=1. With a cycle counter zeroed on that reset edge, the counter reads DIV+1 two edges after tick rises.
- Count, on the same edge that sets tick=1 (no load/clear):
  - Up: MAX -> 0 with wrap<=1; otherwise +1.
  - Down: 0 -> MAX with wrap<=1; otherwise -1.
  - MAX = MODULUS-1, or 2^WIDTH-1 when MODULUS=0.
- count_val changes only on tick, load, clear or reset.
- Load:
  - count_val<=load_val; if MODULUS!=0 and load_val>=MODULUS, count_val<=0.
  - Prescaler is unaffected.
  - Load coincident with a tick edge: load value wins, tick still pulses, wrap<=0.
- Clear: prescaler<=0, count_val<=0, tick<=0, wrap<=0, regardless of enable. A new full DIV period starts.
- Reset mid-period: identical to clear. The partial period is discarded.
- wrap is never high without tick.
- up_dn changes between ticks take effect at the next tick only.
- Widths: all prescaler/count arithmetic is modulo the declared width; no overflow beyond MAX is ever stored.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → DIV=10, MODULUS=6, WIDTH=4, unless noted):
- Release reset, enable=1, up -> tick rises exactly 10 cycles after the reset edge, count_val=1; the 6th tick gives count_val=0 with wrap=1 in the same cycle; tick period is 10 cycles throughout.
- up_dn=0 from reset -> first tick gives count_val=5, wrap=1; next tick gives 4, wrap=0.
- enable=0 for 7 cycles starting 4 cycles into a period -> that tick is delayed by exactly 7 cycles; tick and wrap stay 0 while disabled.
- load=1, load_val=3 on a tick edge with count_val=5 (up) -> count_val=3, tick=1, wrap=0. Then load_val=9 -> count_val=0.
- Assert reset (then, separately, clear) 6 cycles into a period with count_val=4 -> next cycle all outputs 0; next tick arrives 10 cycles later.
- clear and load together with load_val=2 -> count_val=0. Defaults (CLK_HZ=100e6, TICK_HZ=1, WIDTH=8, MODULUS=0) -> first tick after 100_000_000 cycles with count_val=1; 255 wraps to 0 with wrap=1.
